wb_arbiter_queue: RTL and testbench
===================================

// Module: wb_arbiter_queue
// PURPOSE
//  Parametrised EXE->WB collector. NCH execution units each push (rd, result) into a private FIFO.
//  A selectable arbiter drains one entry per cycle into a registered writeback port.
//  The writeback port obeys valid/ready backpressure from the register file.
//  Sits between the execution units (alu, ld, mul, div, ...) and the register-file write port.
// PARAMETERS
//  NCH      4   number of execution channels (1..8)
//  DEPTH    2   entries per channel FIFO (power of 2, >=2)
//  DW       32  result width
//  RW       4   destination-register index width
//  ARB_MODE 0   0 = fixed priority (channel 0 highest); 1 = round robin
//  DROP_RD0 0   1 = pushes with rd==0 are accepted but not stored
// PORTS
//  clk        in   1          clock, all state updates on posedge
//  rst        in   1          synchronous reset, active-high
//  in_valid   in   NCH        channel c presents an entry
//  in_ready   out  NCH        channel c FIFO can accept; = ~rst & ~full[c]
//  in_rd      in   NCH x RW   destination register per channel
//  in_data    in   NCH x DW   result per channel
//  wb_valid   out  1          writeback entry valid (registered)
//  wb_ready   in   1          register file consumes the entry this cycle
//  wb_rd      out  RW         destination register (registered)
//  wb_result  out  DW         result (registered)
//  wb_src     out  clog2(NCH) channel that produced the entry (registered)
// BEHAVIOUR
//  - Reset: all FIFOs empty, pointers 0, rr pointer 0.
//    Outputs cleared: wb_valid=0, wb_rd=0, wb_result=0, wb_src=0.
//    Asserting rst mid-operation discards all queued entries and the output entry.
//  - Push: happens when in_valid[c] & in_ready[c] at a posedge.
//    in_ready does not depend on wb_ready; a full FIFO never accepts, even when it pops that cycle.
//  - Output load: the output register loads when (~wb_valid | wb_ready) and at least one FIFO is non-empty.
//    It loads the arbitration winner's head and pops that FIFO in the same cycle.
//    Otherwise it holds; if wb_ready & nothing is pending, wb_valid goes to 0 (rd/result hold their last values).
//  - Latency: an entry pushed at edge E0 into an empty system shows wb_valid=1 after edge E1.
//    Throughput is 1 entry/cycle sustained.
//  - ARB_MODE 0: the lowest-index non-empty channel wins.
//  - ARB_MODE 1: search starts at rr_ptr. After a grant to channel g, rr_ptr = (g+1) mod NCH.
//    rr_ptr does not move without a grant.
//  - FIFO order is preserved per channel. No ordering is guaranteed across channels.
//  - Wrap-around: read/write pointers are clog2(DEPTH)+1 bits. full = MSBs differ and LSBs equal.
//  - Simultaneous push and pop on one non-full FIFO: count unchanged, both take effect.
//  - The FIFO is never bypassed: an entry pushed at E0 is not eligible before E1.
//  - DROP_RD0=1 with in_rd==0: in_ready behaves normally, the handshake completes, nothing is stored.
// CONFIGURATION
//  WB_PERF_EN defined:
//   - adds perf_wb_cnt (out, 32): counts cycles with wb_valid & wb_ready.
//   - adds perf_stall_cnt (out, NCH x 32): counts cycles with in_valid[c] & ~in_ready[c].
//   - both counters saturate at all-ones and are cleared by rst.
//  WB_PERF_EN undefined: neither port nor counter exists; all other behaviour is identical.
// STRUCTURE
//  - Package wb_pkg:
//    - typedef wb_entry_t {logic [RW-1:0] rd; logic [DW-1:0] data;}
//    - ARB_FIXED=0, ARB_RR=1
//    - function clog2 helper for wb_src / pointer widths
//  - Sub-module wb_chan_fifo (DEPTH, entry type): push/pop/full/empty/head.
//    Instantiated NCH times in a generate loop.
//  - Arbiter and output register live in the top module.
// TESTING
//  - Reset: drive rst=1 for 2 cycles mid-traffic.
//    -> wb_valid=0, wb_rd=0, wb_result=0, in_ready all 0 during reset.
//    -> All FIFOs empty afterwards: no stale entry appears.
//  - Latency: ch2 pushes rd=5, data=0xDEADBEEF at edge E0, wb_ready=1.
//    -> wb_valid=1, wb_rd=5, wb_result=0xDEADBEEF, wb_src=2 after E1; wb_valid=0 after E2.
//  - Fixed priority (ARB_MODE=0): all 4 channels push one entry in the same cycle.
//    -> Drained in order src 0,1,2,3 on 4 consecutive cycles.
//  - Round robin (ARB_MODE=1): ch0 and ch3 each hold 2 entries.
//    -> Grant order 0,3,0,3; rr_ptr ends at 0.
//  - Backpressure/full: wb_ready=0, ch1 pushes 3 entries with DEPTH=2.
//    -> 1 entry moves into the output register; ch1 then fills.
//    -> in_ready[1]=0 after the 3rd push; the 4th push stalls.
//    -> wb_ready=1 releases entries in push order with no loss or duplication.
//  - WB_PERF_EN: repeat the full-FIFO test.
//    -> perf_stall_cnt[1] equals the number of stalled cycles; perf_wb_cnt=3 after draining.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the EXE->WB collector.
package wb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int WB_RW = 4;
    localparam int WB_DW = 32;

    typedef struct packed {
        logic [WB_RW-1:0] rd;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    // Ceiling log2, never below 1 so single-channel builds keep a 1-bit index.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_chan_fifo.sv
// Per-channel FIFO with wrap-bit pointers; head is the oldest entry.
module wb_chan_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];
    logic        do_push, do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        head     = mem_q[rd_ptr_q[AW-1:0]];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        if (do_push) mem_d[wr_ptr_q[AW-1:0]] = din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wb_arbiter_queue.sv
// EXE->WB collector: NCH channel FIFOs, one arbiter, registered WB port.
// Optional WB_PERF_EN adds saturating writeback and per-channel stall counters.
module wb_arbiter_queue
    import wb_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int DEPTH    = 2,
    parameter int DW       = 32,
    parameter int RW       = 4,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int DROP_RD0 = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [NCH*RW-1:0]      in_rd,
    input  logic [NCH*DW-1:0]      in_data,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [RW-1:0]          wb_rd,
    output logic [DW-1:0]          wb_result,
`ifdef WB_PERF_EN
    output logic [31:0]            perf_wb_cnt,
    output logic [NCH*32-1:0]      perf_stall_cnt,
`endif
    output logic [clog2(NCH)-1:0]  wb_src
);

    localparam int SW = clog2(NCH);

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t [NCH-1:0] fifo_din;
    entry_t [NCH-1:0] fifo_head;
    logic   [NCH-1:0] full, empty, push, pop;

    assign in_ready = ~full & {NCH{~rst}};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign fifo_din[c] = '{rd: in_rd[c*RW +: RW], data: in_data[c*DW +: DW]};
        // Dropped rd==0 writes still complete the handshake.
        assign push[c] = in_valid[c] & in_ready[c] &
                         ~((DROP_RD0 != 0) && (in_rd[c*RW +: RW] == '0));

        wb_chan_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (fifo_din[c]),
            .full  (full[c]),
            .empty (empty[c]),
            .head  (fifo_head[c])
        );
    end

    logic          wb_valid_q, wb_valid_d;
    logic [RW-1:0] wb_rd_q, wb_rd_d;
    logic [DW-1:0] wb_result_q, wb_result_d;
    logic [SW-1:0] wb_src_q, wb_src_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] grant;
    logic          any, load;
    int            idx;

    // Scan from the highest offset down so the first eligible channel wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (ARB_MODE == ARB_RR) ? (int'(rr_ptr_q) + k) % NCH : k;
            if (!empty[idx]) begin
                any   = 1'b1;
                grant = SW'(idx);
            end
        end
    end

    always_comb begin
        load        = (~wb_valid_q | wb_ready) & any;
        pop         = '0;
        wb_valid_d  = wb_valid_q;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        wb_src_d    = wb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            pop[grant]  = 1'b1;
            wb_valid_d  = 1'b1;
            wb_rd_d     = fifo_head[grant].rd;
            wb_result_d = fifo_head[grant].data;
            wb_src_d    = grant;
            if (ARB_MODE == ARB_RR) rr_ptr_d = SW'((int'(grant) + 1) % NCH);
        end else if (wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            wb_src_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            wb_src_q    <= wb_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_result = wb_result_q;
    assign wb_src    = wb_src_q;

`ifdef WB_PERF_EN
    logic [31:0]       perf_wb_q, perf_wb_d;
    logic [NCH*32-1:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_wb_d    = perf_wb_q;
        perf_stall_d = perf_stall_q;
        if (wb_valid_q && wb_ready && !(&perf_wb_q)) perf_wb_d = perf_wb_q + 32'd1;
        for (int c = 0; c < NCH; c++) begin
            if (in_valid[c] && !in_ready[c] && !(&perf_stall_q[c*32 +: 32]))
                perf_stall_d[c*32 +: 32] = perf_stall_q[c*32 +: 32] + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wb_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_wb_q    <= perf_wb_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_wb_cnt    = perf_wb_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter_queue.sv
// Scoreboard bench: fixed-priority DUT and round-robin/drop-rd0 DUT share stimulus.
module tb_wb_arbiter_queue;

    localparam int NCH   = 4;
    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int EW    = 2 + RW + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_valid;
    logic [NCH*RW-1:0] in_rd;
    logic [NCH*DW-1:0] in_data;
    logic              wb_ready;

    logic [NCH-1:0] inr   [2];
    logic           wbv   [2];
    logic [RW-1:0]  wbrd  [2];
    logic [DW-1:0]  wbres [2];
    logic [1:0]     wbsrc [2];
`ifdef WB_PERF_EN
    logic [31:0]       pwb [2];
    logic [NCH*32-1:0] pst [2];
`endif

    always #5 clk = ~clk;

    wb_arbiter_queue #(
        .NCH(NCH), .DEPTH(DEPTH), .DW(DW), .RW(RW), .ARB_MODE(0), .DROP_RD0(0)
    ) u_fix (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr[0]),
        .in_rd(in_rd), .in_data(in_data), .wb_valid(wbv[0]), .wb_ready(wb_ready),
        .wb_rd(wbrd[0]), .wb_result(wbres[0]),
`ifdef WB_PERF_EN
        .perf_wb_cnt(pwb[0]), .perf_stall_cnt(pst[0]),
`endif
        .wb_src(wbsrc[0])
    );

    wb_arbiter_queue #(
        .NCH(NCH), .DEPTH(DEPTH), .DW(DW), .RW(RW), .ARB_MODE(1), .DROP_RD0(1)
    ) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inr[1]),
        .in_rd(in_rd), .in_data(in_data), .wb_valid(wbv[1]), .wb_ready(wb_ready),
        .wb_rd(wbrd[1]), .wb_result(wbres[1]),
`ifdef WB_PERF_EN
        .perf_wb_cnt(pwb[1]), .perf_stall_cnt(pst[1]),
`endif
        .wb_src(wbsrc[1])
    );

    // Reference model: per-channel queues plus the output slot.
    logic [RW+DW-1:0] mq   [2][NCH][$];
    logic [EW-1:0]    expq [2][$];
    bit               mov  [2];
    logic [RW-1:0]    mrd  [2];
    logic [DW-1:0]    mdat [2];
    logic [1:0]       msrc [2];
    int               rr   [2];
    int               mwb  [2];
    int               mst  [2][NCH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int m);
        bit               rdy [NCH];
        bit               found;
        int               g, c;
        logic [RW+DW-1:0] ent;
        for (int i = 0; i < NCH; i++) rdy[i] = !rst && (mq[m][i].size() < DEPTH);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                mq[m][i].delete();
                mst[m][i] = 0;
            end
            expq[m].delete();
            mov[m] = 0; mrd[m] = '0; mdat[m] = '0; msrc[m] = '0;
            rr[m] = 0; mwb[m] = 0;
            return;
        end
        if (mov[m] && wb_ready) mwb[m]++;
        for (int i = 0; i < NCH; i++) if (in_valid[i] && !rdy[i]) mst[m][i]++;
        found = 0;
        g = 0;
        if (!mov[m] || wb_ready) begin
            for (int k = 0; k < NCH; k++) begin
                c = (m == 1) ? (rr[m] + k) % NCH : k;
                if (!found && mq[m][c].size() > 0) begin
                    found = 1;
                    g = c;
                end
            end
        end
        if (found) begin
            ent = mq[m][g].pop_front();
            mov[m]  = 1;
            mrd[m]  = ent[RW+DW-1:DW];
            mdat[m] = ent[DW-1:0];
            msrc[m] = 2'(g);
            if (m == 1) rr[m] = (g + 1) % NCH;
            expq[m].push_back({2'(g), ent});
        end else if (wb_ready) begin
            mov[m] = 0;
        end
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[i] && rdy[i] && !(m == 1 && in_rd[i*RW +: RW] == '0))
                mq[m][i].push_back({in_rd[i*RW +: RW], in_data[i*DW +: DW]});
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    logic [NCH-1:0] er;
    logic [EW-1:0]  e;

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < NCH; c++) er[c] = !rst && (mq[m][c].size() < DEPTH);
            chk($sformatf("in_ready[%0d]", m), 64'(inr[m]), 64'(er));
            chk($sformatf("wb_valid[%0d]", m), 64'(wbv[m]), 64'(mov[m]));
            chk($sformatf("wb_rd[%0d]", m), 64'(wbrd[m]), 64'(mrd[m]));
            chk($sformatf("wb_result[%0d]", m), 64'(wbres[m]), 64'(mdat[m]));
            chk($sformatf("wb_src[%0d]", m), 64'(wbsrc[m]), 64'(msrc[m]));
`ifdef WB_PERF_EN
            chk($sformatf("perf_wb[%0d]", m), 64'(pwb[m]), 64'(mwb[m]));
            for (int c = 0; c < NCH; c++)
                chk($sformatf("perf_stall[%0d][%0d]", m, c),
                    64'(pst[m][c*32 +: 32]), 64'(mst[m][c]));
`endif
            if (!rst && wbv[m] && wb_ready) begin
                if (expq[m].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected[%0d] actual=%h required=none",
                             m, {wbsrc[m], wbrd[m], wbres[m]});
                end else begin
                    e = expq[m].pop_front();
                    chk($sformatf("sb_entry[%0d]", m),
                        64'({wbsrc[m], wbrd[m], wbres[m]}), 64'(e));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [RW-1:0] rd, input logic [DW-1:0] d);
        in_rd[c*RW +: RW] = rd;
        in_data[c*DW +: DW] = d;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_rd = '0;
        in_data = '0;
        wb_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // Latency: single entry through an empty system.
        wb_ready = 1'b1;
        set_ch(2, 4'd5, 32'hDEAD_BEEF);
        in_valid = 4'b0100;
        cyc();
        in_valid = '0;
        repeat (4) cyc();

        // All channels push together.
        for (int c = 0; c < NCH; c++) set_ch(c, 4'(c + 1), 32'h100 + c);
        in_valid = 4'hF;
        cyc();
        in_valid = '0;
        repeat (6) cyc();

        // ch0 and ch3 each hold two entries before draining.
        wb_ready = 1'b0;
        set_ch(0, 4'd7, 32'hA0);
        set_ch(3, 4'd8, 32'hB0);
        in_valid = 4'b1001;
        cyc();
        set_ch(0, 4'd7, 32'hA1);
        set_ch(3, 4'd8, 32'hB1);
        cyc();
        in_valid = '0;
        cyc();
        wb_ready = 1'b1;
        repeat (6) cyc();

        // Backpressure fills ch1, then release.
        wb_ready = 1'b0;
        in_valid = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            set_ch(1, 4'(i + 1), 32'hC0DE_0000 + i);
            cyc();
        end
        in_valid = '0;
        wb_ready = 1'b1;
        repeat (6) cyc();

        // Random traffic with a reset pulse in the middle.
        for (int i = 0; i < 3000; i++) begin
            in_valid = 4'($urandom);
            for (int c = 0; c < NCH; c++)
                set_ch(c, ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom), $urandom);
            wb_ready = ($urandom_range(0, 9) < 7);
            rst = (i == 1500 || i == 1501);
            cyc();
        end
        rst = 1'b0;
        in_valid = '0;
        wb_ready = 1'b1;
        repeat (20) cyc();

        for (int m = 0; m < 2; m++)
            chk($sformatf("drain_pending[%0d]", m), 64'(expq[m].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
